axilite_cmd_master: RTL and testbench

//  AXI4-Lite initiator for the L3 peripheral bus. Converts single-beat read/write commands from a simple

---
 rtl/axilite_cmd_master_if.sv | 75 +++++++
 rtl/axilite_cmd_master.sv | 172 +++++++++++++++++
 tb/tb_axilite_cmd_master.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/axilite_cmd_master_if.sv
// Command/response port plus the AXI4-Lite master bus of axilite_cmd_master.
// The master modport is the initiator's view; slave is the peripheral/driver side.
interface axilite_cmd_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_wstrb;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_resp;
  logic              rsp_timeout;

  logic [ADDR_W-1:0] M_AXI_AWADDR;
  logic [2:0]        M_AXI_AWPROT;
  logic              M_AXI_AWVALID;
  logic              M_AXI_AWREADY;
  logic [DATA_W-1:0] M_AXI_WDATA;
  logic [STRB_W-1:0] M_AXI_WSTRB;
  logic              M_AXI_WVALID;
  logic              M_AXI_WREADY;
  logic [1:0]        M_AXI_BRESP;
  logic              M_AXI_BVALID;
  logic              M_AXI_BREADY;
  logic [ADDR_W-1:0] M_AXI_ARADDR;
  logic [2:0]        M_AXI_ARPROT;
  logic              M_AXI_ARVALID;
  logic              M_AXI_ARREADY;
  logic [DATA_W-1:0] M_AXI_RDATA;
  logic [1:0]        M_AXI_RRESP;
  logic              M_AXI_RVALID;
  logic              M_AXI_RREADY;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wstrb,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    input  rsp_ready,
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wstrb,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    output rsp_ready,
    input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/axilite_cmd_master.sv
// Single-outstanding AXI4-Lite initiator: turns one command into one AXI-Lite
// read or write, returns the response, and aborts via a watchdog if the slave dies.
module axilite_cmd_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic                   clk,
  input logic                   rst,
  axilite_cmd_master_if.master  bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int WD_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_REQ  = 3'd1;
  localparam logic [2:0] WR_RESP = 3'd2;
  localparam logic [2:0] RD_REQ  = 3'd3;
  localparam logic [2:0] RD_DATA = 3'd4;
  localparam logic [2:0] RSP     = 3'd5;

  logic [2:0]        state;
  logic              cmd_ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              awvalid;
  logic              wvalid;
  logic              bready;
  logic              arvalid;
  logic              rready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_resp;
  logic              rsp_timeout;
  logic [WD_W-1:0]   wd_cnt;

  logic busy;
  logic wd_expire;
  logic final_hs;
  logic aw_done;
  logic w_done;

  always_comb begin
    busy      = (state == WR_REQ) || (state == WR_RESP) ||
                (state == RD_REQ) || (state == RD_DATA);
    // wd_cnt equals the number of busy cycles so far, including the current one
    wd_expire = (TIMEOUT != 0) && busy && (wd_cnt == WD_W'(TIMEOUT));
    final_hs  = ((state == WR_RESP) && bus.M_AXI_BVALID) ||
                ((state == RD_DATA) && bus.M_AXI_RVALID);
    aw_done   = !awvalid || bus.M_AXI_AWREADY;
    w_done    = !wvalid  || bus.M_AXI_WREADY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      addr        <= '0;
      wdata       <= '0;
      wstrb       <= '0;
      awvalid     <= 1'b0;
      wvalid      <= 1'b0;
      bready      <= 1'b0;
      arvalid     <= 1'b0;
      rready      <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= 2'b00;
      rsp_timeout <= 1'b0;
      wd_cnt      <= '0;
    end else begin
      if (busy) wd_cnt <= wd_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            cmd_ready <= 1'b0;
            addr      <= bus.cmd_addr;
            wd_cnt    <= WD_W'(1);
            if (bus.cmd_we) begin
              wdata   <= bus.cmd_wdata;
              wstrb   <= bus.cmd_wstrb;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= WR_REQ;
            end else begin
              arvalid <= 1'b1;
              state   <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          // AW and W complete independently; move on once neither is pending
          if (awvalid && bus.M_AXI_AWREADY) awvalid <= 1'b0;
          if (wvalid && bus.M_AXI_WREADY) wvalid <= 1'b0;
          if (aw_done && w_done) begin
            bready <= 1'b1;
            state  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bus.M_AXI_BVALID) begin
            bready      <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_resp    <= bus.M_AXI_BRESP;
            rsp_timeout <= 1'b0;
            state       <= RSP;
          end
        end
        RD_REQ: begin
          if (bus.M_AXI_ARREADY) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (bus.M_AXI_RVALID) begin
            rready      <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= bus.M_AXI_RDATA;
            rsp_resp    <= bus.M_AXI_RRESP;
            rsp_timeout <= 1'b0;
            state       <= RSP;
          end
        end
        RSP: begin
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
      // Watchdog abort overrides the normal progress above; a completing B/R handshake still wins
      if (wd_expire && !final_hs) begin
        awvalid     <= 1'b0;
        wvalid      <= 1'b0;
        bready      <= 1'b0;
        arvalid     <= 1'b0;
        rready      <= 1'b0;
        rsp_valid   <= 1'b1;
        rsp_rdata   <= '0;
        rsp_resp    <= 2'b10;
        rsp_timeout <= 1'b1;
        state       <= RSP;
      end
    end
  end

  assign bus.cmd_ready     = cmd_ready;
  assign bus.rsp_valid     = rsp_valid;
  assign bus.rsp_rdata     = rsp_rdata;
  assign bus.rsp_resp      = rsp_resp;
  assign bus.rsp_timeout   = rsp_timeout;
  assign bus.M_AXI_AWADDR  = addr;
  assign bus.M_AXI_AWPROT  = 3'b000;
  assign bus.M_AXI_AWVALID = awvalid;
  assign bus.M_AXI_WDATA   = wdata;
  assign bus.M_AXI_WSTRB   = wstrb;
  assign bus.M_AXI_WVALID  = wvalid;
  assign bus.M_AXI_BREADY  = bready;
  assign bus.M_AXI_ARADDR  = addr;
  assign bus.M_AXI_ARPROT  = 3'b000;
  assign bus.M_AXI_ARVALID = arvalid;
  assign bus.M_AXI_RREADY  = rready;
endmodule

// File: tb/tb_axilite_cmd_master.sv
// Randomized bench for axilite_cmd_master: reactive AXI-Lite slave with per-transaction
// wait states, checked against a latency/response model derived from the slave delays.
module tb_axilite_cmd_master;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  axilite_cmd_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axilite_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_slave();
    bus.M_AXI_AWREADY = 1'b0;
    bus.M_AXI_WREADY  = 1'b0;
    bus.M_AXI_BVALID  = 1'b0;
    bus.M_AXI_BRESP   = 2'b00;
    bus.M_AXI_ARREADY = 1'b0;
    bus.M_AXI_RVALID  = 1'b0;
    bus.M_AXI_RRESP   = 2'b00;
    bus.M_AXI_RDATA   = 32'h0;
  endtask

  function automatic logic [4:0] axi_ctl();
    return {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY,
            bus.M_AXI_ARVALID, bus.M_AXI_RREADY};
  endfunction

  // d_a: AW/AR ready wait, d_w: W ready wait, d_r: B/R valid wait after request phase
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] ws, input int d_a, input int d_w, input int d_r,
                         input logic [1:0] resp, input logic [31:0] rdat, input bit dead,
                         input int hold);
    int a_cnt = 0, w_cnt = 0, r_cnt = 0;
    int n_a = 0, n_w = 0, n_b = 0;
    int rsp_cyc = -1, h, exp_cyc;
    bit a_hs = 0, w_hs = 0, done = 0, bad_fld = 0, unstable = 0;
    bit a_now, w_now;
    logic        to_exp;
    logic [1:0]  resp_exp;
    logic [31:0] rdata_exp;
    logic [31:0] s_rdata;
    logic [1:0]  s_resp;
    logic        s_to;

    // Reference: cycle index (from accept) of the final B/R handshake
    if (we) h = 1 + ((d_a > d_w) ? d_a : d_w) + 1 + d_r;
    else    h = 1 + d_a + 1 + d_r;
    if (dead || h > TO) begin
      exp_cyc = TO + 1; to_exp = 1'b1; resp_exp = 2'b10; rdata_exp = 32'h0;
    end else begin
      exp_cyc = h + 1; to_exp = 1'b0; resp_exp = resp; rdata_exp = we ? 32'h0 : rdat;
    end

    check_eq("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wd;
    bus.cmd_wstrb = ws;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = $urandom();
    bus.cmd_wdata = $urandom();
    bus.cmd_wstrb = 4'($urandom());
    check_eq("busy_cmd_ready", 32'(bus.cmd_ready), 32'd0);

    for (int k = 1; k <= TO + 40; k++) begin
      if (bus.rsp_valid) begin
        rsp_cyc = k;
        break;
      end
      bus.M_AXI_AWREADY = bus.M_AXI_AWVALID && (a_cnt == d_a);
      bus.M_AXI_WREADY  = bus.M_AXI_WVALID && (w_cnt == d_w);
      bus.M_AXI_ARREADY = bus.M_AXI_ARVALID && (a_cnt == d_a);
      bus.M_AXI_BVALID  = we && a_hs && w_hs && !dead && !done && (r_cnt >= d_r);
      bus.M_AXI_RVALID  = !we && a_hs && !dead && !done && (r_cnt >= d_r);
      bus.M_AXI_BRESP   = resp;
      bus.M_AXI_RRESP   = resp;
      bus.M_AXI_RDATA   = bus.M_AXI_RVALID ? rdat : $urandom();
      if (bus.M_AXI_AWVALID && (bus.M_AXI_AWADDR !== addr || bus.M_AXI_AWPROT !== 3'b000)) bad_fld = 1;
      if (bus.M_AXI_ARVALID && (bus.M_AXI_ARADDR !== addr || bus.M_AXI_ARPROT !== 3'b000)) bad_fld = 1;
      if (bus.M_AXI_WVALID && (bus.M_AXI_WDATA !== wd || bus.M_AXI_WSTRB !== ws)) bad_fld = 1;
      if (bus.M_AXI_AWVALID && !we) bad_fld = 1;
      if (bus.M_AXI_ARVALID && we) bad_fld = 1;
      a_now = (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) || (bus.M_AXI_ARVALID && bus.M_AXI_ARREADY);
      w_now = bus.M_AXI_WVALID && bus.M_AXI_WREADY;
      if (a_now) n_a++;
      if (w_now) n_w++;
      if ((bus.M_AXI_BVALID && bus.M_AXI_BREADY) || (bus.M_AXI_RVALID && bus.M_AXI_RREADY)) begin
        n_b++;
        done = 1;
      end
      if (a_hs && (w_hs || !we)) r_cnt++;
      if (bus.M_AXI_AWVALID || bus.M_AXI_ARVALID) a_cnt++;
      if (bus.M_AXI_WVALID) w_cnt++;
      if (a_now) a_hs = 1;
      if (w_now) w_hs = 1;
      @(posedge clk); #1;
    end
    clear_slave();

    check_eq("rsp_latency", 32'(rsp_cyc), 32'(exp_cyc));
    check_eq("rsp_timeout", 32'(bus.rsp_timeout), 32'(to_exp));
    check_eq("rsp_resp", 32'(bus.rsp_resp), 32'(resp_exp));
    check_eq("rsp_rdata", bus.rsp_rdata, rdata_exp);
    check_eq("axi_idle_in_rsp", 32'(axi_ctl()), 32'd0);
    check_eq("axi_fields", 32'(bad_fld), 32'd0);
    if (!to_exp) begin
      check_eq("addr_hs_count", 32'(n_a), 32'd1);
      check_eq("w_hs_count", 32'(n_w), we ? 32'd1 : 32'd0);
      check_eq("resp_hs_count", 32'(n_b), 32'd1);
    end

    s_rdata = bus.rsp_rdata;
    s_resp  = bus.rsp_resp;
    s_to    = bus.rsp_timeout;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!bus.rsp_valid || bus.rsp_rdata !== s_rdata || bus.rsp_resp !== s_resp ||
          bus.rsp_timeout !== s_to || bus.cmd_ready) unstable = 1;
    end
    check_eq("rsp_held_stable", 32'(unstable), 32'd0);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check_eq("rsp_released", 32'(bus.rsp_valid), 32'd0);
    check_eq("cmd_ready_back", 32'(bus.cmd_ready), 32'd1);
    check_eq("axi_idle_after", 32'(axi_ctl()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: bench did not finish");
    $fatal(1);
  end

  initial begin
    bit quiet;
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_addr  = 32'h0;
    bus.cmd_wdata = 32'h0;
    bus.cmd_wstrb = 4'h0;
    bus.rsp_ready = 1'b0;
    clear_slave();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check_eq("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check_eq("reset_axi_ctl", 32'(axi_ctl()), 32'd0);
    check_eq("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    check_eq("reset_rsp_resp", 32'(bus.rsp_resp), 32'd0);
    check_eq("reset_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);

    // Directed cases
    run_txn(1'b1, 32'h0000_0004, 32'h0000_00A5, 4'h1, 0, 0, 0, 2'b00, 32'h0, 1'b0, 0);
    run_txn(1'b1, 32'h0000_0010, 32'h1234_5678, 4'hF, 3, 0, 0, 2'b00, 32'h0, 1'b0, 1);
    run_txn(1'b1, 32'h0000_0020, 32'hCAFE_0000, 4'hC, 0, 2, 1, 2'b00, 32'h0, 1'b0, 0);
    run_txn(1'b0, 32'h0000_0008, 32'h0, 4'h0, 0, 0, 5, 2'b00, 32'hDEAD_BEEF, 1'b0, 0);
    run_txn(1'b1, 32'hFFFF_F000, 32'h0000_0001, 4'h1, 0, 0, 0, 2'b10, 32'h0, 1'b0, 0);
    run_txn(1'b0, 32'hFFFF_F004, 32'h0, 4'h0, 1, 0, 0, 2'b11, 32'h5555_AAAA, 1'b0, 0);
    run_txn(1'b1, 32'h0000_0030, 32'h0BAD_F00D, 4'h3, 0, 0, 0, 2'b00, 32'h0, 1'b1, 2);
    run_txn(1'b0, 32'h0000_0040, 32'h0, 4'h0, 0, 0, 14, 2'b01, 32'h0F0F_F0F0, 1'b0, 0);
    run_txn(1'b0, 32'h0000_0044, 32'h0, 4'h0, 0, 0, 15, 2'b00, 32'h1111_2222, 1'b0, 0);
    run_txn(1'b1, 32'h0000_0048, 32'h3333_4444, 4'h5, 0, 0, 14, 2'b00, 32'h0, 1'b0, 0);
    run_txn(1'b1, 32'h0000_004C, 32'h7777_8888, 4'hA, 0, 0, 15, 2'b00, 32'h0, 1'b0, 0);
    run_txn(1'b0, 32'h0000_0050, 32'h0, 4'h0, 2, 0, 1, 2'b00, 32'h9ABC_DEF0, 1'b0, 4);

    // Reset while ARVALID is high: no response may follow
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b0;
    bus.cmd_addr  = 32'h0000_0100;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("mid_arvalid", 32'(bus.M_AXI_ARVALID), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("mid_rst_axi_ctl", 32'(axi_ctl()), 32'd0);
    check_eq("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check_eq("mid_rst_araddr", bus.M_AXI_ARADDR, 32'h0);
    quiet = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid || axi_ctl() != 5'd0) quiet = 0;
    end
    check_eq("mid_rst_quiet", 32'(quiet), 32'd1);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      run_txn(1'($urandom_range(0, 1)), $urandom(), $urandom(), 4'($urandom()),
              $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 5),
              2'($urandom()), $urandom(), ($urandom_range(0, 7) == 0),
              $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
